// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums,
// the opcode width constant and the multi-cycle op classifier.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } alu_state_e;

  // Shifts and multiplies run on the iterative engine; everything else
  // finishes in a single EXEC cycle.
  function automatic logic is_multicycle(input logic [ALU_OP_W-1:0] op);
    logic r;
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_MULHU: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath shared by the shift ops (SHIFT_STEP bits per cycle,
// remainder on the last step) and the shift-add multiplier (one partial
// product per cycle into a 2*BUS_WIDTH accumulator held as hi/lo halves).
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  alu_op_e              op_i,
  input  logic [BUS_WIDTH-1:0] a_i,
  input  logic [BUS_WIDTH-1:0] b_i,
  output logic                 done_o,
  output logic [BUS_WIDTH-1:0] result_o
);

  localparam int SHW = $clog2(BUS_WIDTH);
  localparam int CW  = SHW + 1;

  logic                 busy_q, busy_d;
  alu_op_e              op_q, op_d;
  logic [BUS_WIDTH-1:0] val_q, val_d;   // shift operand, or multiplicand
  logic [BUS_WIDTH-1:0] hi_q, hi_d;     // accumulator upper half
  logic [BUS_WIDTH-1:0] lo_q, lo_d;     // multiplier bits / accumulator lower half
  logic [CW-1:0]        cnt_q, cnt_d;   // remaining shift bits or multiply steps

  logic                 is_mul;
  logic                 last;
  logic [CW-1:0]        step_amt;
  logic [BUS_WIDTH-1:0] shifted;
  logic [BUS_WIDTH:0]   sum;
  logic [BUS_WIDTH-1:0] hi_nx;
  logic [BUS_WIDTH-1:0] lo_nx;

  // One iteration of whichever operation is in flight, plus next-state.
  always_comb begin
    is_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);
    step_amt = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
    case (op_q)
      OP_SLL:  shifted = val_q << step_amt;
      OP_SRL:  shifted = val_q >> step_amt;
      OP_SRA:  shifted = $unsigned($signed(val_q) >>> step_amt);
      default: shifted = val_q;
    endcase
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, val_q} : '0);
    hi_nx = sum[BUS_WIDTH:1];
    lo_nx = {sum[0], lo_q[BUS_WIDTH-1:1]};
    last  = is_mul ? (cnt_q == CW'(1)) : (cnt_q <= CW'(SHIFT_STEP));

    done_o = busy_q && last;
    case (op_q)
      OP_MUL:   result_o = lo_nx;
      OP_MULHU: result_o = hi_nx;
      default:  result_o = shifted;
    endcase

    busy_d = busy_q;
    op_d   = op_q;
    val_d  = val_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      op_d   = op_i;
      val_d  = a_i;
      hi_d   = '0;
      lo_d   = b_i;
      if ((op_i == OP_MUL) || (op_i == OP_MULHU)) begin
        cnt_d = CW'(BUS_WIDTH);
      end else begin
        cnt_d = {1'b0, b_i[SHW-1:0]};
      end
    end else if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
      end else if (is_mul) begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - CW'(1);
      end else begin
        val_d = shifted;
        cnt_d = cnt_q - step_amt;
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      op_q   <= OP_ADD;
      val_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      val_q  <= val_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU channel: collects rs1/rs2 (or rs1 + immediate) over the
// shared rs_data bus, executes, and returns the result on a valid/ready
// handshake with op_done pulsing on the transfer cycle.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int MUL_EN       = 1,
  parameter int SHIFT_STEP   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    imme_value,
  input  logic                    use_imm,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [BUS_WIDTH-1:0]    rs_data,
  input  logic                    rs_data_sel,
  input  logic                    rs_data_valid,
  output logic                    rs_data_ready,
  output logic [BUS_WIDTH-1:0]    alu_out,
  output logic                    alu_valid_out,
  input  logic                    alu_ready_in,
  output logic                    op_done,
  output logic                    illegal_op,
  output logic                    busy
);

  function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
    logic [ALU_OP_W-1:0] lo;
    logic                ok;
    lo = op[ALU_OP_W-1:0];
    ok = ((op >> ALU_OP_W) == '0) && (lo <= OP_MULHU);
    if ((MUL_EN == 0) && ((lo == OP_MUL) || (lo == OP_MULHU))) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic op_multi(input logic [OPCODE_WIDTH-1:0] op);
    return op_legal(op) && is_multicycle(op[ALU_OP_W-1:0]);
  endfunction

  function automatic logic [BUS_WIDTH-1:0] single_op(
    input logic [ALU_OP_W-1:0]  op,
    input logic [BUS_WIDTH-1:0] a,
    input logic [BUS_WIDTH-1:0] b
  );
    logic [BUS_WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(BUS_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(BUS_WIDTH-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  alu_state_e              state_q, state_d;
  logic [BUS_WIDTH-1:0]    rs1_q, rs1_d;
  logic [BUS_WIDTH-1:0]    b_q, b_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [BUS_WIDTH-1:0]    out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    ill_q, ill_d;

  logic                    accepting;
  logic                    beat;
  logic                    eng_start;
  logic                    eng_done;
  logic [BUS_WIDTH-1:0]    eng_result;
  logic                    exec_done;

  alu_iter_engine #(
    .BUS_WIDTH  (BUS_WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (eng_start),
    .op_i     (alu_op_e'(op_d[ALU_OP_W-1:0])),
    .a_i      (rs1_d),
    .b_i      (b_d),
    .done_o   (eng_done),
    .result_o (eng_result)
  );

  // FSM next-state, operand capture and result formation.
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    b_d       = b_q;
    op_d      = op_q;
    out_d     = out_q;
    valid_d   = valid_q;
    ill_d     = ill_q;
    eng_start = 1'b0;

    accepting = (state_q == IDLE) || (state_q == COLLECT);
    beat      = rs_data_valid && accepting;
    exec_done = op_multi(op_q) ? eng_done : 1'b1;

    case (state_q)
      IDLE, COLLECT: begin
        // rs1 beats (re)start collection; an rs2 beat only counts once rs1 is held.
        if (beat && !rs_data_sel) begin
          rs1_d = rs_data;
          op_d  = op_code;
          if (use_imm) begin
            b_d       = imme_value;
            state_d   = EXEC;
            eng_start = op_multi(op_code);
          end else begin
            state_d = COLLECT;
          end
        end else if (beat && rs_data_sel && (state_q == COLLECT)) begin
          b_d       = rs_data;
          state_d   = EXEC;
          eng_start = op_multi(op_q);
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (!op_legal(op_q)) begin
            out_d = '0;
          end else if (op_multi(op_q)) begin
            out_d = eng_result;
          end else begin
            out_d = single_op(op_q[ALU_OP_W-1:0], rs1_q, b_q);
          end
          ill_d   = !op_legal(op_q);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (alu_ready_in) begin
          out_d   = '0;
          ill_d   = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign rs_data_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign busy          = (state_q != IDLE);
  assign alu_out       = out_q;
  assign alu_valid_out = valid_q;
  assign illegal_op    = ill_q;
  assign op_done       = valid_q && alu_ready_in;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed results and cycle counts.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imme_value;
  logic        use_imm;
  logic [3:0]  op_code;
  logic [31:0] rs_data;
  logic        rs_data_sel;
  logic        rs_data_valid;
  logic        rs_data_ready;
  logic [31:0] alu_out;
  logic        alu_valid_out;
  logic        alu_ready_in;
  logic        op_done;
  logic        illegal_op;
  logic        busy;

  alu_seq_unit #(
    .BUS_WIDTH    (32),
    .OPCODE_WIDTH (4),
    .MUL_EN       (1),
    .SHIFT_STEP   (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imme_value    (imme_value),
    .use_imm       (use_imm),
    .op_code       (op_code),
    .rs_data       (rs_data),
    .rs_data_sel   (rs_data_sel),
    .rs_data_valid (rs_data_valid),
    .rs_data_ready (rs_data_ready),
    .alu_out       (alu_out),
    .alu_valid_out (alu_valid_out),
    .alu_ready_in  (alu_ready_in),
    .op_done       (op_done),
    .illegal_op    (illegal_op),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    p  = 64'(a) * 64'(b);
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return $unsigned($signed(a) >>> sh);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (op >= 4'd7 && op <= 4'd9) return (sh == 0) ? 1 : sh;
    if (op == 4'd10 || op == 4'd11) return 32;
    return 1;
  endfunction

  // phase: 0 nothing held, 1 rs1 held, 2 computing, 3 result offered
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_a     = '0;
  logic [3:0]  m_op    = '0;
  logic [31:0] m_res   = '0;
  logic        m_ill   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0, 1: begin
          if (rs_data_valid && !rs_data_sel) begin
            m_a  <= rs_data;
            m_op <= op_code;
            if (use_imm) begin
              m_phase <= 2;
              m_left  <= ref_cycles(op_code, imme_value);
              m_res   <= ref_res(op_code, rs_data, imme_value);
              m_ill   <= (op_code > 4'd11);
            end else begin
              m_phase <= 1;
            end
          end else if (m_phase == 1 && rs_data_valid && rs_data_sel) begin
            m_phase <= 2;
            m_left  <= ref_cycles(m_op, rs_data);
            m_res   <= ref_res(m_op, m_a, rs_data);
            m_ill   <= (m_op > 4'd11);
          end
        end
        2: begin
          if (m_left <= 1) m_phase <= 3;
          else m_left <= m_left - 1;
        end
        3: begin
          if (alu_ready_in) m_phase <= 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rdy", rs_data_ready, (m_phase <= 1));
      chk("m_busy", busy, (m_phase != 0));
      chk("m_valid", alu_valid_out, (m_phase == 3));
      chk("m_done", op_done, (m_phase == 3) && alu_ready_in);
      if (m_phase == 3) begin
        chk("m_out", alu_out, m_res);
        chk("m_ill", illegal_op, m_ill);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] d, input logic [3:0] op, input logic ui, input logic [31:0] imm);
    rs_data = d; op_code = op; use_imm = ui; imme_value = imm;
    rs_data_sel = 1'b0; rs_data_valid = 1'b1;
    step();
    rs_data_valid = 1'b0;
  endtask

  task automatic send2(input logic [31:0] d);
    rs_data = d; rs_data_sel = 1'b1; rs_data_valid = 1'b1;
    step();
    rs_data_valid = 1'b0; rs_data_sel = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!alu_valid_out && n < 100) begin
      step();
      n++;
    end
    if (!alu_valid_out) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got timeout want alu_valid_out");
    end
  endtask

  task automatic accept();
    alu_ready_in = 1'b1;
    step();
    alu_ready_in = 1'b0;
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic ui, input logic [31:0] exp_out, input int exp_cyc);
    int n;
    send1(a, op, ui, b);
    if (!ui) send2(b);
    wait_valid(n);
    chk({nm, "_cyc"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_out"}, alu_out, exp_out);
    accept();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dn;
    rst = 1'b1; imme_value = '0; use_imm = 1'b0; op_code = '0; rs_data = '0;
    rs_data_sel = 1'b0; rs_data_valid = 1'b0; alu_ready_in = 1'b0;
    step();
    step();
    chk("rst_rdy", rs_data_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", alu_valid_out, 1'b0);
    chk("rst_out", alu_out, 32'h0);
    chk("rst_done", op_done, 1'b0);
    chk("rst_ill", illegal_op, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    // ADD wraps, valid one edge after rs2, op_done pulses once
    alu_ready_in = 1'b1;
    send1(32'hFFFF_FFFF, 4'd0, 1'b0, 32'h0);
    send2(32'h1);
    chk("add_busy", busy, 1'b1);
    step();
    chk("add_valid", alu_valid_out, 1'b1);
    chk("add_out", alu_out, 32'h0);
    chk("add_done", op_done, 1'b1);
    step();
    chk("add_done_gone", op_done, 1'b0);
    chk("add_valid_gone", alu_valid_out, 1'b0);
    alu_ready_in = 1'b0;

    run("sra4",  4'd9,  32'h8000_0000, 32'd4,  1'b1, 32'hF800_0000, 4);
    run("sra0",  4'd9,  32'h8000_0000, 32'd0,  1'b1, 32'h8000_0000, 1);
    run("sll31", 4'd7,  32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000, 31);
    run("srl8",  4'd8,  32'hF000_0000, 32'd8,  1'b0, 32'h00F0_0000, 8);
    run("sub",   4'd1,  32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1);
    run("slt",   4'd5,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 1);
    run("sltu",  4'd6,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1);
    run("and",   4'd2,  32'hA5A5_A5A5, 32'h0FF0_0FF0, 1'b0, 32'h05A0_05A0, 1);
    run("or",    4'd3,  32'hA5A5_A5A5, 32'h0FF0_0FF0, 1'b0, 32'hAFF5_AFF5, 1);
    run("xor",   4'd4,  32'hA5A5_A5A5, 32'h0FF0_0FF0, 1'b0, 32'hAA55_AA55, 1);
    run("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32);
    run("mul",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32);
    run("mul2",  4'd10, 32'd12345, 32'd1000, 1'b0, 32'd12345000, 32);

    // back-pressure with a pending rs1 beat
    send1(32'd3, 4'd0, 1'b1, 32'd4);
    wait_valid(n);
    rs_data = 32'd100; op_code = 4'd0; use_imm = 1'b1; imme_value = 32'd1;
    rs_data_sel = 1'b0; rs_data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out", alu_out, 32'd7);
      chk("bp_rdy", rs_data_ready, 1'b0);
    end
    alu_ready_in = 1'b1;
    #1;
    chk("bp_done", op_done, 1'b1);
    step();
    alu_ready_in = 1'b0;
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_rdy", rs_data_ready, 1'b1);
    step();
    rs_data_valid = 1'b0;
    chk("bp_taken", busy, 1'b1);
    wait_valid(n);
    chk("bp_next_out", alu_out, 32'd101);
    accept();

    // protocol edges
    send2(32'd55);
    chk("rs2_drop", busy, 1'b0);
    send1(32'd10, 4'd0, 1'b0, 32'd0);
    send1(32'd20, 4'd1, 1'b0, 32'd0);
    send2(32'd5);
    wait_valid(n);
    chk("ovw_out", alu_out, 32'd15);
    accept();
    send1(32'd1, 4'd0, 1'b0, 32'd0);
    send1(32'd40, 4'd0, 1'b1, 32'd2);
    wait_valid(n);
    chk("ovw_imm_cyc", 32'(n), 32'd1);
    chk("ovw_imm_out", alu_out, 32'd42);
    accept();
    send1(32'd9, 4'd15, 1'b1, 32'd3);
    wait_valid(n);
    chk("ill_cyc", 32'(n), 32'd1);
    chk("ill_out", alu_out, 32'd0);
    chk("ill_flag", illegal_op, 1'b1);
    accept();
    chk("ill_clear", illegal_op, 1'b0);

    // reset during MUL EXEC cycle 10
    send1(32'hFFFF_FFFF, 4'd10, 1'b0, 32'd0);
    send2(32'd3);
    repeat (9) step();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("rst2_valid", alu_valid_out, 1'b0);
    chk("rst2_out", alu_out, 32'h0);
    chk("rst2_ill", illegal_op, 1'b0);
    chk("rst2_done", op_done, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_rdy", rs_data_ready, 1'b1);
    rst = 1'b0;
    alu_ready_in = 1'b1;
    dn = 0;
    repeat (40) begin
      step();
      if (op_done || alu_valid_out) dn++;
    end
    alu_ready_in = 1'b0;
    chk("rst2_no_done", 32'(dn), 32'd0);

    run("post_rst", 4'd0, 32'd2, 32'd3, 1'b0, 32'd5, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
